// File: rtl/procb_writer_pkg.sv
// Shared sizing for the sha256crypt procb record path.
// Record layout, buffer geometry and small helpers used by the writer and its bench.
package procb_writer_pkg;

    localparam int N_THREADS_DEF   = 4;
    localparam int PROCB_D_WIDTH   = 16;
    localparam int PROCB_A_WIDTH   = 4;
    localparam int PROCB_N_RECORDS = 8;
    localparam int PROCB_STOP_BIT  = 15;
    localparam int PROCB_FIN_BIT   = 14;

    localparam logic [PROCB_A_WIDTH-1:0] PROCB_N_REC_A = PROCB_A_WIDTH'(PROCB_N_RECORDS);

    // Index of the highest set bit; 0 for an argument of 0.
    function automatic int msb(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // A stop or finish record ends the current load request.
    function automatic logic rec_is_last(input logic [PROCB_D_WIDTH-1:0] rec);
        return rec[PROCB_STOP_BIT] | rec[PROCB_FIN_BIT];
    endfunction

endpackage

// File: rtl/procb_writer.sv
// procb_writer: loads one thread's slot of the procb record buffer from the CPU record stream.
// Latency: accept -> WAIT -> LOAD -> first write at cycle 3; done the cycle after the last write.
// Backpressure: req_ready only in IDLE; rec_ready only in WRITE while the slot has room; no timeout.
module procb_writer
    import procb_writer_pkg::*;
#(
    parameter int N_THREADS     = N_THREADS_DEF,
    parameter int N_THREADS_MSB = msb(N_THREADS - 1)
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [N_THREADS_MSB:0]     req_thread_num,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [PROCB_D_WIDTH-1:0]   rec_din,
    input  logic                       rec_valid,
    output logic                       rec_ready,
    output logic [N_THREADS_MSB:0]     wr_thread_num,
    output logic                       wr_en,
    output logic [PROCB_D_WIDTH-1:0]   dout,
    input  logic [PROCB_A_WIDTH-1:0]   wr_cnt,
    output logic                       busy,
    output logic                       done,
    output logic [N_THREADS_MSB:0]     done_thread_num,
    output logic [PROCB_A_WIDTH-1:0]   n_written,
    output logic                       full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [PROCB_A_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PROCB_A_WIDTH-1:0]   n_written_q, n_written_d;
    logic                       full_q, full_d;
    logic [N_THREADS_MSB:0]     wr_thread_num_q, wr_thread_num_d;
    logic [PROCB_A_WIDTH-1:0]   cnt_inc;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            n_written_q     <= '0;
            full_q          <= 1'b0;
            wr_thread_num_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            n_written_q     <= n_written_d;
            full_q          <= full_d;
            wr_thread_num_q <= wr_thread_num_d;
        end
    end

    assign cnt_inc = cnt_q + PROCB_A_WIDTH'(1);

    // Gating with RESET keeps the abort cycle from writing a half-accepted record.
    assign rec_ready = (state_q == S_WRITE) && (cnt_q < PROCB_N_REC_A) && !RESET;
    assign wr_en     = rec_valid && rec_ready;
    assign dout      = rec_din;

    assign req_ready       = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign wr_thread_num   = wr_thread_num_q;
    assign done_thread_num = wr_thread_num_q;
    assign n_written       = n_written_q;
    assign full            = full_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        n_written_d     = n_written_q;
        full_d          = full_q;
        wr_thread_num_d = wr_thread_num_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_thread_num_d = req_thread_num;
                    n_written_d     = '0;
                    full_d          = 1'b0;
                    state_d         = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // wr_cnt is trusted only here; the reader may clear it later.
                if (wr_cnt >= PROCB_N_REC_A) begin
                    cnt_d   = PROCB_N_REC_A;
                    full_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = wr_cnt;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_en) begin
                    cnt_d       = cnt_inc;
                    n_written_d = n_written_q + PROCB_A_WIDTH'(1);
                    if (rec_is_last(rec_din)) begin
                        full_d  = 1'b0;
                        state_d = S_DONE;
                    end else if (cnt_inc == PROCB_N_REC_A) begin
                        full_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_procb_writer.sv
// Bench for procb_writer with a behavioural procb buffer and a per-request reference model.
module tb_procb_writer;
    import procb_writer_pkg::*;

    localparam int NT = 4;
    localparam int TW = msb(NT - 1) + 1;
    localparam int N  = PROCB_N_RECORDS;
    localparam int DW = PROCB_D_WIDTH;
    localparam int AW = PROCB_A_WIDTH;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [TW-1:0] req_thread_num;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] rec_din;
    logic          rec_valid;
    logic          rec_ready;
    logic [TW-1:0] wr_thread_num;
    logic          wr_en;
    logic [DW-1:0] dout;
    logic [AW-1:0] wr_cnt;
    logic          busy;
    logic          done;
    logic [TW-1:0] done_thread_num;
    logic [AW-1:0] n_written;
    logic          full;

    always #5 CLK = ~CLK;

    procb_writer #(.N_THREADS(NT)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .req_thread_num  (req_thread_num),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .rec_din         (rec_din),
        .rec_valid       (rec_valid),
        .rec_ready       (rec_ready),
        .wr_thread_num   (wr_thread_num),
        .wr_en           (wr_en),
        .dout            (dout),
        .wr_cnt          (wr_cnt),
        .busy            (busy),
        .done            (done),
        .done_thread_num (done_thread_num),
        .n_written       (n_written),
        .full            (full)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural procb buffer: per-thread record counts with a registered count lookup.
    int            bufcnt [NT];
    logic          clr_req;
    logic          wr_en_s;
    logic [TW-1:0] thr_s;

    always @(negedge CLK) begin
        wr_en_s = wr_en;
        thr_s   = wr_thread_num;
    end

    always @(posedge CLK) begin
        if (clr_req) bufcnt[thr_s] = 0;
        if (wr_en_s) bufcnt[thr_s] = bufcnt[thr_s] + 1;
        wr_cnt <= AW'(bufcnt[thr_s]);
    end

    logic [DW-1:0] rec_q [$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_rec(input bit term, input bit use_fin);
        logic [DW-1:0] r;
        r = DW'($urandom);
        r[PROCB_STOP_BIT] = 1'b0;
        r[PROCB_FIN_BIT]  = 1'b0;
        if (term) begin
            if (use_fin) r[PROCB_FIN_BIT] = 1'b1;
            else         r[PROCB_STOP_BIT] = 1'b1;
        end
        return r;
    endfunction

    // One load request. The model: writes start at cycle 3, each offered record is taken
    // until a stop/finish record or the slot holds N records; done follows the last write.
    task automatic run_req(input int t, input int c0, input logic [31:0] mask, input bit rnd,
                           input int abort_after, input int clr_cycle);
        int nw, cnt, done_k;
        bit fin, full_e, exp_wr, rst_now, in_wr, done_seen, aborted;
        logic [DW-1:0] cur;
        bufcnt[t] = c0;
        nw = 0; cnt = c0; fin = 0; full_e = 0; done_k = -1; done_seen = 0; aborted = 0;
        if (c0 >= N) begin
            fin = 1; full_e = 1; done_k = 3;
        end
        req_valid = 1'b1;
        req_thread_num = TW'(t);
        rec_valid = 1'b0;
        rec_din = mk_rec(0, 0);
        @(negedge CLK);
        chk_eq("req_ready_idle", 32'(req_ready), 32'd1);
        chk_eq("busy_idle", 32'(busy), 32'd0);
        @(posedge CLK); #1;
        for (int k = 1; k <= 80; k++) begin
            rst_now = (abort_after > 0) && (nw == abort_after);
            in_wr   = (k >= 3) && !fin;
            RESET   = rst_now;
            clr_req = (k == clr_cycle);
            req_valid = 1'($urandom_range(0, 1));
            req_thread_num = TW'($urandom);
            rec_valid = (rec_q.size() > 0) && (rnd ? ($urandom_range(0, 2) != 0) : ((k < 32) && mask[k]));
            rec_din   = (rec_q.size() > 0) ? rec_q[0] : DW'($urandom);
            cur       = rec_din;
            exp_wr    = in_wr && rec_valid && !rst_now;
            @(negedge CLK);
            chk_eq("wr_en", 32'(wr_en), 32'(exp_wr));
            chk_eq("rec_ready", 32'(rec_ready), 32'(in_wr && !rst_now));
            chk_eq("busy", 32'(busy), 32'd1);
            chk_eq("req_ready_busy", 32'(req_ready), 32'd0);
            chk_eq("done", 32'(done), 32'(k == done_k));
            chk_eq("wr_thread_num", 32'(wr_thread_num), 32'(t));
            if (exp_wr) chk_eq("dout", 32'(dout), 32'(cur));
            if (k == done_k) begin
                chk_eq("n_written", 32'(n_written), 32'(nw));
                chk_eq("full", 32'(full), 32'(full_e));
                chk_eq("done_thread_num", 32'(done_thread_num), 32'(t));
            end
            if (exp_wr) begin
                void'(rec_q.pop_front());
                nw++;
                cnt++;
                if (cur[PROCB_STOP_BIT] || cur[PROCB_FIN_BIT]) begin
                    fin = 1; full_e = 0; done_k = k + 1;
                end else if (cnt == N) begin
                    fin = 1; full_e = 1; done_k = k + 1;
                end
            end
            @(posedge CLK); #1;
            clr_req = 1'b0;
            if (rst_now) begin
                aborted   = 1;
                RESET     = 1'b0;
                req_valid = 1'b0;
                rec_valid = 1'b0;
                @(negedge CLK);
                chk_eq("abort_req_ready", 32'(req_ready), 32'd1);
                chk_eq("abort_busy", 32'(busy), 32'd0);
                chk_eq("abort_done", 32'(done), 32'd0);
                chk_eq("abort_n_written", 32'(n_written), 32'd0);
                chk_eq("abort_wr_thread", 32'(wr_thread_num), 32'd0);
                chk_eq("abort_kept_records", 32'(bufcnt[t]), 32'(c0 + nw));
                @(posedge CLK); #1;
                break;
            end
            if (k == done_k) begin
                done_seen = 1;
                break;
            end
        end
        req_valid = 1'b0;
        rec_valid = 1'b0;
        if (!aborted && !done_seen) begin
            chk_eq("timeout", 32'd0, 32'd1);
            RESET = 1'b1;
            @(posedge CLK); #1;
            RESET = 1'b0;
        end else if (!aborted) begin
            @(negedge CLK);
            chk_eq("req_ready_after_done", 32'(req_ready), 32'd1);
            chk_eq("done_low_after", 32'(done), 32'd0);
            if (clr_cycle < 0) chk_eq("buffer_count", 32'(bufcnt[t]), 32'(c0 + nw));
            @(posedge CLK); #1;
        end
        rec_q.delete();
    endtask

    initial begin
        RESET = 1'b1;
        req_valid = 1'b0;
        req_thread_num = '0;
        rec_valid = 1'b1;
        rec_din = '0;
        clr_req = 1'b0;
        for (int i = 0; i < NT; i++) bufcnt[i] = 0;
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk_eq("rst_req_ready", 32'(req_ready), 32'd1);
        chk_eq("rst_rec_ready", 32'(rec_ready), 32'd0);
        chk_eq("rst_wr_en", 32'(wr_en), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_done", 32'(done), 32'd0);
        chk_eq("rst_full", 32'(full), 32'd0);
        chk_eq("rst_n_written", 32'(n_written), 32'd0);
        chk_eq("rst_wr_thread", 32'(wr_thread_num), 32'd0);
        chk_eq("rst_done_thread", 32'(done_thread_num), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        rec_valid = 1'b0;

        // Three records, stop on the third, valid held high.
        rec_q.push_back(mk_rec(0, 0)); rec_q.push_back(mk_rec(0, 0)); rec_q.push_back(mk_rec(1, 0));
        run_req(3, 0, 32'hFFFF_FFFF, 0, 0, -1);

        // Two free entries, five plain records offered.
        for (int i = 0; i < 5; i++) rec_q.push_back(mk_rec(0, 0));
        run_req(1, N - 2, 32'hFFFF_FFFF, 0, 0, -1);

        // Slot already full.
        rec_q.push_back(mk_rec(0, 0)); rec_q.push_back(mk_rec(0, 0));
        run_req(0, N, 32'hFFFF_FFFF, 0, 0, -1);

        // Gapped valid: record in WAIT is ignored, writes at cycles 3 and 6.
        rec_q.push_back(mk_rec(0, 0)); rec_q.push_back(mk_rec(1, 1));
        run_req(2, 0, 32'h0000_004A, 0, 0, -1);

        // Reset the cycle after the second of four writes, then a normal request.
        for (int i = 0; i < 3; i++) rec_q.push_back(mk_rec(0, 0));
        rec_q.push_back(mk_rec(1, 0));
        run_req(1, 0, 32'hFFFF_FFFF, 0, 2, -1);
        rec_q.push_back(mk_rec(0, 0)); rec_q.push_back(mk_rec(1, 0));
        run_req(2, 0, 32'hFFFF_FFFF, 0, 0, -1);

        // Reader clears the count mid-write; the writer keeps its own count.
        for (int i = 0; i < 3; i++) rec_q.push_back(mk_rec(0, 0));
        rec_q.push_back(mk_rec(1, 1));
        run_req(2, 3, 32'hFFFF_FFFF, 0, 0, 4);

        for (int r = 0; r < 25; r++) begin
            int t, c0, n, clr;
            t = $urandom_range(0, NT - 1);
            case ($urandom_range(0, 3))
                0:       c0 = N;
                1:       c0 = N - 1;
                default: c0 = $urandom_range(0, N - 1);
            endcase
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++)
                rec_q.push_back(mk_rec((i == n - 1) || ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1));
            clr = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 8) : -1;
            run_req(t, c0, 32'd0, 1, 0, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
